// File: rtl/debug_slave_sysclk_bridge.sv
// System-clock half of the JTAG debug slave: toggle synchronisers, command FIFO, action strobes.
// Optional macro DBG_BRIDGE_PARITY_EN adds jtag_par and a sticky parity_err flag.
module debug_slave_sysclk_bridge #(
  parameter int unsigned DATA_W      = 38,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACTION_BIT  = 35
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          jtag_udr_tgl,
  input  logic                          jtag_uir_tgl,
  input  logic [IR_W-1:0]               jtag_ir,
  input  logic [DATA_W-1:0]             jtag_sr,
`ifdef DBG_BRIDGE_PARITY_EN
  input  logic                          jtag_par,
  output logic                          parity_err,
`endif
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [DATA_W-1:0]             cmd_data,
  output logic [(2**IR_W)-1:0]          take_action,
  output logic [(2**IR_W)-1:0]          take_no_action,
  output logic                          ir_changed,
  output logic                          ack_tgl,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int unsigned LANES = 2 ** IR_W;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic                   udr_prev;
  logic                   uir_prev;
  logic                   udr_evt;
  logic                   uir_evt;
  logic                   par_ok;
  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   drop;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_nxt;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [LANES-1:0]       lane_sel;
  cmd_t                   mem [FIFO_DEPTH];
  cmd_t                   head;

  // Toggle synchronisers; prev tracks the synced level even in reset so release is silent.
  always_ff @(posedge clk) begin
    udr_sync <= {udr_sync[SYNC_STAGES-2:0], jtag_udr_tgl};
    uir_sync <= {uir_sync[SYNC_STAGES-2:0], jtag_uir_tgl};
    udr_prev <= udr_sync[SYNC_STAGES-1];
    uir_prev <= uir_sync[SYNC_STAGES-1];
  end

  assign udr_evt = (udr_sync[SYNC_STAGES-1] ^ udr_prev) & ~reset;
  assign uir_evt = (uir_sync[SYNC_STAGES-1] ^ uir_prev) & ~reset;

`ifdef DBG_BRIDGE_PARITY_EN
  logic par_fail;
  assign par_ok   = ~^{jtag_ir, jtag_sr, jtag_par};
  assign par_fail = udr_evt & ~par_ok;
`else
  assign par_ok = 1'b1;
`endif

  assign push_req  = udr_evt & par_ok;
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = cmd_valid & cmd_ready;
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign count_nxt = CNT_W'(count + CNT_W'(push) - CNT_W'(pop));

  assign head     = mem[rd_ptr];
  assign cmd_ir   = head.ir;
  assign cmd_data = head.data;
  assign lane_sel = LANES'(1) << head.ir;
  assign fifo_level = count;

  // Storage is not reset; contents are only observed while cmd_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_t'({jtag_ir, jtag_sr});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cmd_valid      <= 1'b0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_changed     <= 1'b0;
      ack_tgl        <= 1'b0;
      overflow       <= 1'b0;
`ifdef DBG_BRIDGE_PARITY_EN
      parity_err     <= 1'b0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
      end
      if (pop) begin
        rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
      end
      count          <= count_nxt;
      cmd_valid      <= (count_nxt != '0);
      take_action    <= (pop &&  head.data[ACTION_BIT]) ? lane_sel : '0;
      take_no_action <= (pop && !head.data[ACTION_BIT]) ? lane_sel : '0;
      ack_tgl        <= ack_tgl ^ pop;
      ir_changed     <= uir_evt;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
`ifdef DBG_BRIDGE_PARITY_EN
      if (par_fail) begin
        parity_err <= 1'b1;
      end else if (clr_overflow) begin
        parity_err <= 1'b0;
      end
`endif
    end
  end

endmodule
